bcd_digit_formatter: RTL

BCD_DIGIT_FORMATTER -- requirements
Module: bcd_digit_formatter

---
 rtl/sseg_pkg.sv | 29 ++
 rtl/bcd_add3.sv | 17 +
 rtl/bcd_digit_formatter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the BCD digit formatter and its
// seven-segment display neighbours.
package sseg_pkg;

   localparam int          NUM_DIGITS  = 8;
   localparam int unsigned MAX_DECIMAL = 32'd99_999_999;

   typedef struct packed {
      logic       en;
      logic [3:0] num;
      logic       dp;
   } digit_field_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FORMAT  = 2'd2
   } fmt_state_t;

   function automatic digit_field_t make_field(input logic en, input logic [3:0] num,
                                               input logic dp);
      digit_field_t f;
      f.en  = en;
      f.num = num;
      f.dp  = dp;
      return f;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values of five or more get three added
// so the following left shift carries correctly into the next decade.
module bcd_add3 (
   input  logic [3:0] bcd_in,
   output logic [3:0] bcd_out
);

   // add-3 correction
   always_comb begin
      if (bcd_in >= 4'd5) begin
         bcd_out = bcd_in + 4'd3;
      end else begin
         bcd_out = bcd_in;
      end
   end

endmodule

// File: rtl/bcd_digit_formatter.sv
// Binary to eight-digit BCD converter feeding the display driver's digit fields.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros; otherwise all digits are lit.
module bcd_digit_formatter
   import sseg_pkg::*;
#(
   parameter int WIDTH = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic             dp_en,
   input  logic [2:0]       dp_pos,
   output logic [5:0]       d0,
   output logic [5:0]       d1,
   output logic [5:0]       d2,
   output logic [5:0]       d3,
   output logic [5:0]       d4,
   output logic [5:0]       d5,
   output logic [5:0]       d6,
   output logic [5:0]       d7,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   fmt_state_t       state_r;
   logic [WIDTH-1:0] operand_r;
   logic [31:0]      bcd_r;
   logic [CW-1:0]    count_r;
   logic             dp_en_r;
   logic [2:0]       dp_pos_r;
   logic             ovf_pend_r;
   logic             busy_r;
   logic             done_r;
   logic             overflow_r;
   digit_field_t     digits_r [NUM_DIGITS];

   logic [31:0]      adjusted_s;
   logic             unused_msb_s;
   digit_field_t     fields_s [NUM_DIGITS];
   logic             lit_above_s;
   logic             en_s;
   logic [3:0]       num_s;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .bcd_in  (bcd_r[4*g +: 4]),
         .bcd_out (adjusted_s[4*g +: 4])
      );
   end

   // The top corrected bit is shifted out; value range guarantees it is zero when used.
   assign unused_msb_s = adjusted_s[31];

   // Build the display fields from the finished accumulator, scanning from the top digit down.
   always_comb begin
      lit_above_s = 1'b0;
      en_s        = 1'b0;
      num_s       = 4'd0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         num_s = bcd_r[4*i +: 4];
         if (num_s != 4'd0) begin
            lit_above_s = 1'b1;
         end else begin
            lit_above_s = lit_above_s;
         end
`ifdef LEADING_ZERO_BLANK_EN
         en_s = lit_above_s || (i == 0) || (dp_en_r && (3'(i) <= dp_pos_r));
`else
         en_s = 1'b1;
`endif
         if (ovf_pend_r) begin
            fields_s[i] = make_field(1'b1, 4'hF, 1'b0);
         end else begin
            fields_s[i] = make_field(en_s, num_s, dp_en_r && (3'(i) == dp_pos_r));
         end
      end
   end

   // Control FSM, double-dabble datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         operand_r  <= '0;
         bcd_r      <= 32'd0;
         count_r    <= '0;
         dp_en_r    <= 1'b0;
         dp_pos_r   <= 3'd0;
         ovf_pend_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_r[i] <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  operand_r  <= value;
                  dp_en_r    <= dp_en;
                  dp_pos_r   <= dp_pos;
                  ovf_pend_r <= ({{(32-WIDTH){1'b0}}, value} > MAX_DECIMAL);
                  bcd_r      <= 32'd0;
                  count_r    <= CW'(WIDTH);
                  busy_r     <= 1'b1;
                  state_r    <= CONVERT;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            CONVERT: begin
               bcd_r     <= {adjusted_s[30:0], operand_r[WIDTH-1]};
               operand_r <= operand_r << 1;
               count_r   <= count_r - CW'(1);
               if (count_r == CW'(1)) begin
                  state_r <= FORMAT;
               end else begin
                  state_r <= CONVERT;
               end
            end
            FORMAT: begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  digits_r[i] <= fields_s[i];
               end
               overflow_r <= ovf_pend_r;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign d0       = digits_r[0];
   assign d1       = digits_r[1];
   assign d2       = digits_r[2];
   assign d3       = digits_r[3];
   assign d4       = digits_r[4];
   assign d5       = digits_r[5];
   assign d6       = digits_r[6];
   assign d7       = digits_r[7];
   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = overflow_r;

endmodule
